// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter for 16-bit result words: raw high/low byte pair by default,
// or four uppercase hex digits plus CR/LF when UART_WORD_TX_ASCII_HEX_EN is defined.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              busy,
  output logic              byte_sent,
  output logic              uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_WORD_TX_ASCII_HEX_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_reg;
  logic [CW-1:0]     baud_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [2:0]        byte_idx_reg;
  logic [WORD_W-1:0] word_reg;
  logic [7:0]        shift_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              ready_reg;
  logic              sent_reg;
  logic [7:0]        sel_byte;
  logic              baud_last;

  assign baud_last = (baud_cnt_reg == BAUD_LAST);

`ifdef UART_WORD_TX_ASCII_HEX_EN
  // 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37)
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    sel_byte = 8'h0A;
    case (byte_idx_reg)
      3'd0:    sel_byte = hex_char(word_reg[15:12]);
      3'd1:    sel_byte = hex_char(word_reg[11:8]);
      3'd2:    sel_byte = hex_char(word_reg[7:4]);
      3'd3:    sel_byte = hex_char(word_reg[3:0]);
      3'd4:    sel_byte = 8'h0D;
      default: sel_byte = 8'h0A;
    endcase
  end
`else
  always_comb begin
    sel_byte = (byte_idx_reg == 3'd0) ? word_reg[15:8] : word_reg[7:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      sent_reg     <= 1'b0;
    end else begin
      sent_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (word_valid) begin
            word_reg     <= word_in;
            byte_idx_reg <= '0;
            busy_reg     <= 1'b1;
            ready_reg    <= 1'b0;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          shift_reg    <= sel_byte;
          tx_reg       <= 1'b0;
          baud_cnt_reg <= '0;
          state_reg    <= START;
        end
        START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              // shift_reg[1] becomes the next bit once the register shifts
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= shift_reg[1];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            sent_reg     <= 1'b1;
            if (byte_idx_reg == LAST_BYTE) begin
              busy_reg  <= 1'b0;
              ready_reg <= 1'b1;
              state_reg <= IDLE;
            end else begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
              state_reg    <= LOAD;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign uart_tx    = tx_reg;
  assign busy       = busy_reg;
  assign word_ready = ready_reg;
  assign byte_sent  = sent_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: two instances (4 and 2 clocks per bit) are
// compared every cycle against a frame-level model built from the byte sequence.
module tb_uart_word_tx;

`ifdef UART_WORD_TX_ASCII_HEX_EN
  localparam int NB = 6;
  localparam logic [7:0] EXP1 [6] = '{8'h33, 8'h41, 8'h37, 8'h46, 8'h0D, 8'h0A};
`else
  localparam int NB = 2;
  localparam logic [7:0] EXP1 [6] = '{8'h3A, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
  localparam int CPB0 = 4;
  localparam int CPB1 = 2;

  typedef struct packed {
    logic tx;
    logic busy;
    logic ready;
    logic bs;
  } samp_t;

  localparam samp_t IDLE_S = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, bs: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] word_in = 16'h0;
  logic        word_valid = 1'b0;
  logic        tx_w    [2];
  logic        busy_w  [2];
  logic        ready_w [2];
  logic        bs_w    [2];

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(CPB0), .WORD_W(16)) u0 (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready_w[0]), .busy(busy_w[0]), .byte_sent(bs_w[0]), .uart_tx(tx_w[0])
  );

  uart_word_tx #(.CLKS_PER_BIT(CPB1), .WORD_W(16)) u1 (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready_w[1]), .busy(busy_w[1]), .byte_sent(bs_w[1]), .uart_tx(tx_w[1])
  );

  // k-th byte sent for a word
  function automatic logic [7:0] nth_byte(input logic [15:0] w, input int k);
    logic [3:0] n;
`ifdef UART_WORD_TX_ASCII_HEX_EN
    if (k == 4) return 8'h0D;
    if (k == 5) return 8'h0A;
    n = 4'((w >> (12 - 4 * k)) & 16'hF);
    if (n < 4'd10) return 8'(48 + int'(n));
    return 8'(65 + int'(n) - 10);
`else
    n = 4'h0;
    return (k == 0) ? w[15:8] : w[7:0] ^ {4'h0, n};
`endif
  endfunction

  // Behavioural model: on acceptance, the whole per-cycle timeline of the word is queued.
  samp_t expq [2][$];
  samp_t cur  [2];
  int    acc_cnt [2];

  always @(posedge clk or posedge reset) begin
    logic [7:0] mb;
    int cpb;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        expq[i].delete();
        cur[i] = IDLE_S;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cpb = (i == 0) ? CPB0 : CPB1;
        if (cur[i].ready && word_valid) begin
          acc_cnt[i]++;
          for (int k = 0; k < NB; k++) begin
            mb = nth_byte(word_in, k);
            expq[i].push_back(samp_t'{1'b1, 1'b1, 1'b0, (k > 0)});
            for (int c = 0; c < cpb; c++) expq[i].push_back(samp_t'{1'b0, 1'b1, 1'b0, 1'b0});
            for (int bi = 0; bi < 8; bi++)
              for (int c = 0; c < cpb; c++) expq[i].push_back(samp_t'{mb[bi], 1'b1, 1'b0, 1'b0});
            for (int c = 0; c < cpb; c++) expq[i].push_back(samp_t'{1'b1, 1'b1, 1'b0, 1'b0});
          end
          expq[i].push_back(samp_t'{1'b1, 1'b0, 1'b1, 1'b1});
        end
        if (expq[i].size() > 0) cur[i] = expq[i].pop_front();
        else cur[i] = IDLE_S;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // line decoder on instance 0
  bit         dec_on = 1'b0;
  int         dec_p = 0;
  int         hi_run = 0;
  int         bs_cnt = 0;
  logic [7:0] dec_byte;
  logic [7:0] dec_q [$];
  int         run_q [$];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        chk(tx_w[i] === cur[i].tx, $sformatf("uart_tx[%0d]", i), int'(tx_w[i]), int'(cur[i].tx));
        chk(busy_w[i] === cur[i].busy, $sformatf("busy[%0d]", i), int'(busy_w[i]), int'(cur[i].busy));
        chk(ready_w[i] === cur[i].ready, $sformatf("word_ready[%0d]", i), int'(ready_w[i]), int'(cur[i].ready));
        chk(bs_w[i] === cur[i].bs, $sformatf("byte_sent[%0d]", i), int'(bs_w[i]), int'(cur[i].bs));
      end
      if (bs_w[0]) bs_cnt++;
      if (dec_on) begin
        dec_p++;
        if (dec_p >= CPB0 && dec_p < 9 * CPB0 && (dec_p % CPB0) == 0)
          dec_byte[dec_p / CPB0 - 1] = tx_w[0];
        if (dec_p == 9 * CPB0) begin
          dec_q.push_back(dec_byte);
          dec_on = 1'b0;
          hi_run = 1;
        end
      end else if (tx_w[0] == 1'b0) begin
        dec_on = 1'b1;
        dec_p = 0;
        run_q.push_back(hi_run);
        hi_run = 0;
      end else begin
        hi_run++;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(expq[0].size() == 0 && cur[0].ready && expq[1].size() == 0 && cur[1].ready)
           && n < bound) begin
      tick();
      n++;
    end
    chk(n < bound, "idle_timeout", n, bound);
  endtask

  task automatic send_pulse(input logic [15:0] w);
    word_in = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_accept(input int prev, input int bound);
    int n = 0;
    while (acc_cnt[0] == prev && n < bound) begin
      tick();
      n++;
    end
    chk(n < bound, "accept_timeout", n, bound);
  endtask

  task automatic check_dec(input logic [15:0] w, input string name);
    chk(dec_q.size() == NB, {name, "_count"}, dec_q.size(), NB);
    for (int k = 0; k < NB && k < dec_q.size(); k++)
      chk(dec_q[k] == nth_byte(w, k), name, int'(dec_q[k]), int'(nth_byte(w, k)));
  endtask

  initial begin
    int prev;
    logic [15:0] rw;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk(tx_w[0] === 1'b1 && busy_w[0] === 1'b0, "reset_tx_busy", int'({tx_w[0], busy_w[0]}), 2);
    chk(ready_w[0] === 1'b1 && bs_w[0] === 1'b0, "reset_ready_bs", int'({ready_w[0], bs_w[0]}), 2);

    for (int k = 0; k < NB; k++)
      chk(nth_byte(16'h3A7F, k) == EXP1[k], "model_bytes", int'(nth_byte(16'h3A7F, k)), int'(EXP1[k]));

    // single word, one-cycle valid pulse
    dec_q.delete();
    bs_cnt = 0;
    send_pulse(16'h3A7F);
    wait_idle(2000);
    chk(dec_q.size() == NB, "t1_count", dec_q.size(), NB);
    for (int k = 0; k < NB && k < dec_q.size(); k++)
      chk(dec_q[k] == EXP1[k], "t1_byte", int'(dec_q[k]), int'(EXP1[k]));
    chk(bs_cnt == NB, "t1_byte_sent_pulses", bs_cnt, NB);

    // back-to-back words with valid held high
    repeat (3) tick();
    dec_q.delete();
    run_q.delete();
    word_in = 16'h0001;
    word_valid = 1'b1;
    prev = acc_cnt[0];
    wait_accept(prev, 50);
    word_in = 16'hFFFF;
    prev = acc_cnt[0];
    wait_accept(prev, 2000);
    word_valid = 1'b0;
    wait_idle(2000);
    chk(dec_q.size() == 2 * NB, "t3_count", dec_q.size(), 2 * NB);
    for (int k = 0; k < 2 * NB && k < dec_q.size(); k++) begin
      rw = (k < NB) ? 16'h0001 : 16'hFFFF;
      chk(dec_q[k] == nth_byte(rw, k % NB), "t3_byte", int'(dec_q[k]), int'(nth_byte(rw, k % NB)));
    end
    if (run_q.size() > NB) begin
      chk(run_q[1] == CPB0 + 1, "t3_byte_gap", run_q[1], CPB0 + 1);
      chk(run_q[NB] == CPB0 + 2, "t3_word_gap", run_q[NB], CPB0 + 2);
    end else begin
      chk(1'b0, "t3_runs", run_q.size(), NB + 1);
    end

    // valid during DATA is ignored
    repeat (2) tick();
    dec_q.delete();
    send_pulse(16'hBEEF);
    repeat (20) tick();
    word_in = 16'h1234;
    word_valid = 1'b1;
    repeat (10) tick();
    word_valid = 1'b0;
    wait_idle(2000);
    check_dec(16'hBEEF, "t4_byte");

    // reset during the third data bit of the first byte
    repeat (2) tick();
    send_pulse(16'h5555);
    begin
      int n = 0;
      while (!(dec_on && dec_p == 3 * CPB0 + 1) && n < 200) begin
        tick();
        n++;
      end
      chk(n < 200, "t5_reach_bit2", n, 200);
    end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(tx_w[i] === 1'b1, "t5_async_tx", int'(tx_w[i]), 1);
      chk(busy_w[i] === 1'b0, "t5_async_busy", int'(busy_w[i]), 0);
      chk(ready_w[i] === 1'b1, "t5_async_ready", int'(ready_w[i]), 1);
    end
    repeat (2) tick();
    reset = 1'b0;
    dec_on = 1'b0;
    hi_run = 0;
    dec_q.delete();
    repeat (2) tick();
    send_pulse(16'h00AA);
    wait_idle(2000);
    check_dec(16'h00AA, "t5_byte");

    // minimum baud divider word (instance 1 checked cycle by cycle)
    send_pulse(16'h8001);
    wait_idle(2000);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      word_in = 16'($urandom);
      word_valid = 1'b1;
      repeat ($urandom_range(1, 60)) tick();
      word_valid = 1'b0;
      repeat ($urandom_range(0, 30)) tick();
    end
    wait_idle(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
